// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: per-register control
// encodings and the controller's sequencing states.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_STREAM = 2'b00,
        HZ_FLUSH  = 2'b01,
        HZ_KEEP   = 2'b11
    } hz_ctrl_t;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_PEND,
        HZ_DRAIN,
        HZ_HALT
    } hz_state_t;

    function automatic logic ctrl_is_keep(input hz_ctrl_t c);
        return c == HZ_KEEP;
    endfunction

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating event counter; clear wins over increment, reset wins over both.
module hz_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-register stream/flush/keep controls, a
// pending-redirect register for busy fetch, a drain sequencer and counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NSTAGE     = 5,
    parameter int REDIR_KILL = 1,
    parameter int XLEN       = 64,
    parameter int CNT_W      = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NSTAGE-1:0]              wait_i,
    input  logic [NSTAGE-1:0]              stage_valid_i,
    input  logic                           redirect_i,
    input  logic [XLEN-1:0]                redirect_pc_i,
    input  logic                           drain_req_i,
    input  logic                           cnt_clr_i,
    output logic [NSTAGE-1:0][1:0]         ctrl_o,
    output logic                           pc_sel_o,
    output logic [XLEN-1:0]                pc_target_o,
    output logic                           drain_busy_o,
    output logic                           drain_done_o,
    output logic [NSTAGE-1:0][CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]               flush_cnt_o
);

    hz_state_t                state_q;
    hz_state_t                state_d;
    logic      [XLEN-1:0]     pend_pc_q;
    logic      [XLEN-1:0]     pend_pc_d;
    logic                     drain_done_q;
    logic                     drain_done_d;

    hz_ctrl_t  [NSTAGE-1:0]   stall_ctrl;
    hz_ctrl_t  [NSTAGE-1:0]   ctrl;
    logic                     ds_stall;
    logic                     fetch_wait;
    logic                     drain_block;
    logic                     pipe_empty;
    logic                     pc_sel;
    logic                     unused_bit0;

    assign fetch_wait  = wait_i[1];
    assign drain_block = (state_q == HZ_DRAIN) || (state_q == HZ_HALT);
    assign pipe_empty  = (stage_valid_i[NSTAGE-1:1] == '0);
    assign unused_bit0 = wait_i[0] ^ stage_valid_i[0];

    // The oldest busy stage (k >= 2) bubbles itself and freezes everything younger.
    always_comb begin
        logic seen;
        seen       = 1'b0;
        ds_stall   = 1'b0;
        stall_ctrl = '{default: HZ_STREAM};
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (seen) begin
                stall_ctrl[k] = HZ_KEEP;
            end else if ((k >= 2) && wait_i[k]) begin
                stall_ctrl[k] = HZ_FLUSH;
                seen          = 1'b1;
                ds_stall      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HZ_RUN;
            pend_pc_q    <= '0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_pc_q    <= pend_pc_d;
            drain_done_q <= drain_done_d;
        end
    end

    // A downstream stall freezes the sequencer; otherwise a redirect that meets
    // a busy fetch is parked in PEND, which also defers any drain request.
    always_comb begin
        state_d      = state_q;
        pend_pc_d    = pend_pc_q;
        drain_done_d = 1'b0;
        if (!ds_stall) begin
            if (redirect_i && fetch_wait) begin
                state_d   = HZ_PEND;
                pend_pc_d = redirect_pc_i;
            end else begin
                unique case (state_q)
                    HZ_RUN: begin
                        if (drain_req_i) begin
                            state_d = HZ_DRAIN;
                        end
                    end
                    HZ_PEND: begin
                        if (!fetch_wait) begin
                            state_d = HZ_RUN;
                        end
                    end
                    HZ_DRAIN: begin
                        if (pipe_empty && !fetch_wait) begin
                            state_d      = HZ_HALT;
                            drain_done_d = 1'b1;
                        end
                    end
                    HZ_HALT: begin
                        if (!drain_req_i) begin
                            state_d = HZ_RUN;
                        end
                    end
                    default: state_d = HZ_RUN;
                endcase
            end
        end
    end

    always_comb begin
        ctrl        = '{default: HZ_STREAM};
        pc_sel      = 1'b0;
        pc_target_o = redirect_pc_i;
        if (ds_stall) begin
            ctrl = stall_ctrl;
        end else begin
            if (redirect_i && !fetch_wait) begin
                pc_sel = 1'b1;
                for (int k = 1; k <= REDIR_KILL; k++) begin
                    ctrl[k] = HZ_FLUSH;
                end
            end else if (redirect_i) begin
                ctrl[0] = HZ_KEEP;
                ctrl[1] = HZ_KEEP;
                for (int k = 2; k <= REDIR_KILL + 1; k++) begin
                    ctrl[k] = HZ_FLUSH;
                end
            end else if (state_q == HZ_PEND) begin
                if (fetch_wait) begin
                    ctrl[0] = HZ_KEEP;
                    ctrl[1] = HZ_KEEP;
                    ctrl[2] = HZ_FLUSH;
                end else begin
                    pc_sel      = 1'b1;
                    pc_target_o = pend_pc_q;
                    ctrl[1]     = HZ_FLUSH;
                end
            end else if (fetch_wait) begin
                ctrl[0] = HZ_KEEP;
                ctrl[1] = HZ_FLUSH;
            end
            // While draining or halted the PC may still be retargeted, but fetch never restarts.
            if (drain_block) begin
                ctrl[0] = HZ_KEEP;
                ctrl[1] = fetch_wait ? HZ_KEEP : HZ_FLUSH;
            end
        end
    end

    assign ctrl_o       = ctrl;
    assign pc_sel_o     = pc_sel;
    assign drain_busy_o = (state_q == HZ_DRAIN);
    assign drain_done_o = drain_done_q;

    for (genvar g = 0; g < NSTAGE; g++) begin : g_stall_cnt
        hz_sat_counter #(
            .CNT_W (CNT_W)
        ) u_stall_cnt (
            .clk     (clk),
            .reset   (reset),
            .inc     (ctrl_is_keep(ctrl[g])),
            .clr     (cnt_clr_i),
            .count_o (stall_cnt_o[g])
        );
    end

    hz_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc     (pc_sel),
        .clr     (cnt_clr_i),
        .count_o (flush_cnt_o)
    );

endmodule
